treehash_ctrl: RTL and testbench
================================

# treehash_ctrl

Sequencer for Merkle-tree root computation using the treehash algorithm. It accepts leaf nodes one at a time and keeps pending subtree roots on the external node `stack`, driving that stack's `push`/`pop`/`inp_data` and reading its `out_data`. It issues left/right pairs to a two-to-one hash core and emits the tree root once all 2^HEIGHT leaves have been absorbed. It sits between the leaf generator and the node stack / hash core in the signature datapath.

## Interface
- `DATA_WIDTH`, 32: node width; must equal the node stack data width.
- `HEIGHT`, 4: tree height (1..16); leaves per tree = 2^HEIGHT.
- `STACK_LAT`, 2: cycles from `stk_pop` pulse to valid `stk_data_out`.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `start` in 1: one-cycle pulse; begins a new tree; ignored while `busy`.
- `leaf_valid` in 1, `leaf_ready` out 1, `leaf_data` in DATA_WIDTH: leaf input handshake.
- `hash_req_valid` out 1, `hash_ready` in 1: hash request handshake.
- `hash_left`, `hash_right` out DATA_WIDTH: hash operands.
- `hash_resp_valid` in 1, `hash_resp_data` in DATA_WIDTH: hash result.
- `stk_push`, `stk_pop` out 1: stack controls. Mutually exclusive one-cycle pulses.
- `stk_data_in` out DATA_WIDTH: node being pushed.
- `stk_data_out` in DATA_WIDTH: popped node.
- `stk_empty`, `stk_full` in 1: stack status.
- `root_valid` out 1: one-cycle pulse when the root is complete.
- `root_data` out DATA_WIDTH: tree root; held until the next `start`.
- `busy` out 1: high from `start` acceptance until `root_valid` or error.
- `error` out 1: sticky overflow/underflow flag; cleared by `start` or reset.

## Operation
- Internal state: `cur_node`, `cur_h` (clog2(HEIGHT+1) bits), and a leaf counter (HEIGHT+1 bits).
- An internal height-tag array of HEIGHT entries with pointer `hsp` mirrors the node stack. The node stack itself stores data only.
- FSM states:
  - IDLE: on `start`, go to WAIT_LEAF.
  - WAIT_LEAF: `leaf_ready`=1. On handshake: `cur_node`←leaf, `cur_h`←0, count++, go to CHECK.
  - CHECK:
    - If `hsp`≠0 and top tag == `cur_h`, go to POP.
    - Else if `cur_h`==HEIGHT, go to DONE.
    - Else go to PUSH.
  - POP: pulse `stk_pop`, decrement `hsp`, go to POP_WAIT. If `stk_empty`=1, go to ERROR instead.
  - POP_WAIT: wait STACK_LAT cycles, then latch `stk_data_out` as the left operand and go to HASH_REQ.
  - HASH_REQ: `hash_req_valid`=1 with left = popped node, right = `cur_node`. On `hash_ready`, go to HASH_WAIT.
  - HASH_WAIT: on `hash_resp_valid`: `cur_node`←resp, `cur_h`++, go to CHECK.
  - PUSH: pulse `stk_push` with `stk_data_in`=`cur_node`; tag[`hsp`]←`cur_h`; `hsp`++. Go to WAIT_LEAF. If `stk_full`=1, go to ERROR instead.
  - DONE: `root_data`←`cur_node`, pulse `root_valid`, go to IDLE.
  - ERROR: `error`=1, `busy`=0. Exit only via `start` (go to WAIT_LEAF) or reset.
- Leaves beyond 2^HEIGHT are never accepted: `leaf_ready`=0 outside WAIT_LEAF.

## Timing
- Reset values: every output 0; FSM in IDLE; `hsp`, `cur_h` and the leaf counter 0.
- `leaf_ready`, `hash_req_valid`, `stk_push` and `stk_pop` are registered outputs.
- Operand and `stk_data_in` values are stable while their valid/pulse is high.
- `hash_req_valid` stays high, with operands held, until `hash_ready`.
- `hash_resp_valid` is honoured only in HASH_WAIT; a response outside HASH_WAIT is ignored.
- Minimum latency per pop-hash step: 1 (POP) + STACK_LAT + 1 (REQ) + hash latency + 1 (CHECK).
- A `start` arriving in the same cycle as `root_valid` is ignored.
- Reset assertion mid-tree aborts immediately. The node stack must be reset in parallel; this block does not drain it.

## Structure
- Shared package `pq_pkg`: FSM state enum `treehash_state_t` and the height-tag width function.
- No sub-module. The node stack and hash core are external peers, connected at the level above.

## Test plan
- HEIGHT=2, hash model = left+right, leaves 1,2,3,4 → `root_data`=10. Exactly 3 `stk_push` and 3 `stk_pop` pulses; one `root_valid` pulse.
- Same tree with `hash_ready` delayed 5 cycles per request → operands held throughout; `root_data`=10.
- HEIGHT=1, leaves 7,9 → root 16; `hsp` returns to 0; `busy` falls with `root_valid`.
- `stk_full` forced high on the first push → `error`=1, `busy`=0. A following `start` clears `error` and `leaf_ready` rises.
- Reset asserted during HASH_WAIT → all outputs 0 asynchronously. After release, a fresh 4-leaf tree gives the correct root.
- `start` pulsed while `busy` and a spurious `hash_resp_valid` in WAIT_LEAF → both ignored; root unchanged.

Source files
------------

// File: rtl/pq_pkg.sv
// Shared types for the signature datapath: treehash sequencer states and
// the sizing helper for height tags.
package pq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT_LEAF,
    ST_CHECK,
    ST_POP,
    ST_POP_WAIT,
    ST_HASH_REQ,
    ST_HASH_WAIT,
    ST_PUSH,
    ST_DONE,
    ST_ERROR
  } treehash_state_t;

  function automatic int unsigned tag_width(input int unsigned height);
    return (height < 1) ? 1 : $clog2(height + 1);
  endfunction

endpackage

// File: rtl/treehash_ctrl.sv
// Treehash sequencer: absorbs 2^HEIGHT leaves, merges equal-height subtree
// roots through the external node stack and hash core, and emits the root.
module treehash_ctrl
  import pq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned HEIGHT     = 4,
  parameter int unsigned STACK_LAT  = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  leaf_valid,
  output logic                  leaf_ready,
  input  logic [DATA_WIDTH-1:0] leaf_data,
  output logic                  hash_req_valid,
  input  logic                  hash_ready,
  output logic [DATA_WIDTH-1:0] hash_left,
  output logic [DATA_WIDTH-1:0] hash_right,
  input  logic                  hash_resp_valid,
  input  logic [DATA_WIDTH-1:0] hash_resp_data,
  output logic                  stk_push,
  output logic                  stk_pop,
  output logic [DATA_WIDTH-1:0] stk_data_in,
  input  logic [DATA_WIDTH-1:0] stk_data_out,
  input  logic                  stk_empty,
  input  logic                  stk_full,
  output logic                  root_valid,
  output logic [DATA_WIDTH-1:0] root_data,
  output logic                  busy,
  output logic                  error
);

  localparam int unsigned TW = tag_width(HEIGHT);
  localparam int unsigned IW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned LW = (STACK_LAT > 1) ? $clog2(STACK_LAT + 1) : 1;
  localparam int unsigned CW = HEIGHT + 1;

  treehash_state_t r_state, w_next;

  logic [DATA_WIDTH-1:0] r_cur_node, r_left, r_root;
  logic [TW-1:0]         r_cur_h, r_hsp;
  logic [TW-1:0]         r_tag [HEIGHT];
  logic [CW-1:0]         r_leaf_cnt;
  logic [LW-1:0]         r_lat;
  logic                  r_leaf_ready, r_hash_req, r_push, r_pop;
  logic                  r_root_valid, r_busy, r_error;
  logic                  w_leaf_fire, w_tag_hit, w_cnt_full;
  logic [IW-1:0]         w_top_idx;

  assign w_leaf_fire = r_leaf_ready && leaf_valid;
  assign w_top_idx   = IW'(r_hsp - TW'(1));
  assign w_tag_hit   = (r_hsp != '0) && (r_tag[w_top_idx] == r_cur_h);
  // A full counter left over from the previous tree must not block a restart.
  assign w_cnt_full  = r_leaf_cnt[HEIGHT] && (r_state != ST_IDLE) && (r_state != ST_ERROR);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (start) w_next = ST_WAIT_LEAF;
      ST_WAIT_LEAF: if (w_leaf_fire) w_next = ST_CHECK;
      ST_CHECK: begin
        if (w_tag_hit)                   w_next = ST_POP;
        else if (r_cur_h == TW'(HEIGHT)) w_next = ST_DONE;
        else                             w_next = ST_PUSH;
      end
      ST_POP:       w_next = stk_empty ? ST_ERROR : ST_POP_WAIT;
      ST_POP_WAIT:  if (r_lat == LW'(STACK_LAT)) w_next = ST_HASH_REQ;
      ST_HASH_REQ:  if (hash_ready) w_next = ST_HASH_WAIT;
      ST_HASH_WAIT: if (hash_resp_valid) w_next = ST_CHECK;
      ST_PUSH:      w_next = stk_full ? ST_ERROR : ST_WAIT_LEAF;
      ST_DONE:      w_next = ST_IDLE;
      ST_ERROR:     if (start) w_next = ST_WAIT_LEAF;
      default:      w_next = ST_IDLE;
    endcase
  end

  // Push/pop pulses are registered, so they are qualified on CHECK's view of
  // the stack status; the stack cannot change between CHECK and POP/PUSH.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_cur_node   <= '0;
      r_left       <= '0;
      r_root       <= '0;
      r_cur_h      <= '0;
      r_hsp        <= '0;
      r_leaf_cnt   <= '0;
      r_lat        <= '0;
      r_leaf_ready <= 1'b0;
      r_hash_req   <= 1'b0;
      r_push       <= 1'b0;
      r_pop        <= 1'b0;
      r_root_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_error      <= 1'b0;
      for (int unsigned i = 0; i < HEIGHT; i++) r_tag[i] <= '0;
    end else begin
      r_state      <= w_next;
      r_leaf_ready <= (w_next == ST_WAIT_LEAF) && !w_cnt_full;
      r_hash_req   <= (w_next == ST_HASH_REQ);
      r_push       <= (w_next == ST_PUSH) && !stk_full;
      r_pop        <= (w_next == ST_POP) && !stk_empty;
      r_root_valid <= (w_next == ST_DONE);
      r_busy       <= !(w_next inside {ST_IDLE, ST_DONE, ST_ERROR});
      r_error      <= (w_next == ST_ERROR);
      if (w_next == ST_DONE) r_root <= r_cur_node;

      case (r_state)
        ST_IDLE, ST_ERROR: begin
          if (start) begin
            r_hsp      <= '0;
            r_cur_h    <= '0;
            r_leaf_cnt <= '0;
          end
        end
        ST_WAIT_LEAF: begin
          if (w_leaf_fire) begin
            r_cur_node <= leaf_data;
            r_cur_h    <= '0;
            r_leaf_cnt <= r_leaf_cnt + CW'(1);
          end
        end
        ST_POP: begin
          if (!stk_empty) begin
            r_hsp <= r_hsp - TW'(1);
            r_lat <= LW'(1);
          end
        end
        ST_POP_WAIT: begin
          if (r_lat == LW'(STACK_LAT)) r_left <= stk_data_out;
          else                         r_lat  <= r_lat + LW'(1);
        end
        ST_HASH_WAIT: begin
          if (hash_resp_valid) begin
            r_cur_node <= hash_resp_data;
            r_cur_h    <= r_cur_h + TW'(1);
          end
        end
        ST_PUSH: begin
          if (!stk_full) begin
            r_tag[IW'(r_hsp)] <= r_cur_h;
            r_hsp             <= r_hsp + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign leaf_ready     = r_leaf_ready;
  assign hash_req_valid = r_hash_req;
  assign hash_left      = r_left;
  assign hash_right     = r_cur_node;
  assign stk_push       = r_push;
  assign stk_pop        = r_pop;
  assign stk_data_in    = r_cur_node;
  assign root_valid     = r_root_valid;
  assign root_data      = r_root;
  assign busy           = r_busy;
  assign error          = r_error;

endmodule

// File: tb/tb_treehash_ctrl.sv
// Directed bench for treehash_ctrl: instance 0 has HEIGHT=2, instance 1 has
// HEIGHT=1; each has its own node-stack (latency 2) and adder hash model.
module tb_treehash_ctrl;

  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n [2];
  logic          start [2];
  logic          leaf_valid [2];
  logic [DW-1:0] leaf_data [2];
  logic          force_full [2];
  logic          spur [2];
  int            rdy_dly [2];

  logic          leaf_ready [2];
  logic          hreq [2];
  logic          hash_ready [2];
  logic [DW-1:0] hleft [2];
  logic [DW-1:0] hright [2];
  logic          resp_v [2];
  logic [DW-1:0] resp_d [2];
  logic          push [2];
  logic          pop [2];
  logic [DW-1:0] sdin [2];
  logic [DW-1:0] sdout [2];
  logic          sempty [2];
  logic          sfull [2];
  logic          root_v [2];
  logic [DW-1:0] root_d [2];
  logic          busy [2];
  logic          err [2];

  int push_cnt [2];
  int pop_cnt [2];
  int rv_cnt [2];
  int excl_cnt [2];
  int hold_cnt [2];
  int hs_cnt [2];
  int depth [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    treehash_ctrl #(.DATA_WIDTH(DW), .HEIGHT(2 - g), .STACK_LAT(2)) u_dut (
      .clock(clk), .reset(rst_n[g]), .start(start[g]),
      .leaf_valid(leaf_valid[g]), .leaf_ready(leaf_ready[g]), .leaf_data(leaf_data[g]),
      .hash_req_valid(hreq[g]), .hash_ready(hash_ready[g]),
      .hash_left(hleft[g]), .hash_right(hright[g]),
      .hash_resp_valid(resp_v[g]), .hash_resp_data(resp_d[g]),
      .stk_push(push[g]), .stk_pop(pop[g]), .stk_data_in(sdin[g]),
      .stk_data_out(sdout[g]), .stk_empty(sempty[g]), .stk_full(sfull[g]),
      .root_valid(root_v[g]), .root_data(root_d[g]), .busy(busy[g]), .error(err[g])
    );

    logic [DW-1:0] mem [16];
    logic [DW-1:0] st1, st2;
    int dep;
    always @(posedge clk or negedge rst_n[g]) begin
      if (!rst_n[g]) begin
        dep <= 0; st1 <= '0; st2 <= '0;
      end else begin
        st2 <= st1;
        if (push[g]) begin mem[dep[3:0]] <= sdin[g]; dep <= dep + 1; end
        if (pop[g])  begin st1 <= mem[dep[3:0] - 4'd1]; dep <= dep - 1; end
      end
    end
    assign sdout[g]  = st2;
    assign sempty[g] = (dep <= 0);
    assign sfull[g]  = (dep >= 8) || force_full[g];
    assign depth[g]  = dep;

    logic          hv_seen, m_rdy, m_rv;
    logic [DW-1:0] hl, hr, sum, m_rd;
    int            wcnt, lcnt;
    int            n_hold = 0, n_hs = 0;
    always @(posedge clk or negedge rst_n[g]) begin
      if (!rst_n[g]) begin
        hv_seen <= 1'b0; m_rdy <= 1'b0; m_rv <= 1'b0; m_rd <= '0;
        hl <= '0; hr <= '0; sum <= '0; wcnt <= 0; lcnt <= 0;
      end else begin
        m_rv <= 1'b0;
        if (lcnt == 1) begin m_rv <= 1'b1; m_rd <= sum; end
        if (lcnt > 0) lcnt <= lcnt - 1;
        if (hreq[g]) begin
          if (!hv_seen) begin hl <= hleft[g]; hr <= hright[g]; end
          else if (hleft[g] != hl || hright[g] != hr) n_hold <= n_hold + 1;
          if (m_rdy) begin
            m_rdy <= 1'b0; hv_seen <= 1'b0; wcnt <= 0;
            sum <= hleft[g] + hright[g]; lcnt <= 3; n_hs <= n_hs + 1;
          end else begin
            hv_seen <= 1'b1; wcnt <= wcnt + 1;
            if (wcnt >= rdy_dly[g]) m_rdy <= 1'b1;
          end
        end
      end
    end
    assign hash_ready[g] = m_rdy;
    assign resp_v[g]     = m_rv | spur[g];
    assign resp_d[g]     = spur[g] ? 32'd999 : m_rd;
    assign hold_cnt[g]   = n_hold;
    assign hs_cnt[g]     = n_hs;

    int n_push = 0, n_pop = 0, n_rv = 0, n_excl = 0;
    always @(posedge clk) begin
      if (push[g]) n_push <= n_push + 1;
      if (pop[g]) n_pop <= n_pop + 1;
      if (root_v[g]) n_rv <= n_rv + 1;
      if (push[g] && pop[g]) n_excl <= n_excl + 1;
    end
    assign push_cnt[g] = n_push;
    assign pop_cnt[g]  = n_pop;
    assign rv_cnt[g]   = n_rv;
    assign excl_cnt[g] = n_excl;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input int g);
    @(negedge clk); start[g] = 1'b1;
    @(negedge clk); start[g] = 1'b0;
  endtask

  task automatic feed_leaf(input int g, input logic [DW-1:0] v);
    int t = 0;
    leaf_valid[g] = 1'b1;
    leaf_data[g]  = v;
    while (!leaf_ready[g] && t < 200) begin @(negedge clk); t++; end
    check_eq("leaf_ready_seen", leaf_ready[g], 1);
    @(negedge clk);
    leaf_valid[g] = 1'b0;
  endtask

  task automatic wait_root(input int g, output logic [DW-1:0] r, output logic b);
    int t = 0;
    while (!root_v[g] && t < 500) begin @(negedge clk); t++; end
    check_eq("root_valid_seen", root_v[g], 1);
    r = root_d[g];
    b = busy[g];
    @(negedge clk);
    check_eq("root_valid_one_cycle", root_v[g], 0);
  endtask

  task automatic run_four(input int g, input logic [DW-1:0] base, output logic [DW-1:0] r,
                          output logic b);
    for (int i = 0; i < 4; i++) feed_leaf(g, base + DW'(i));
    wait_root(g, r, b);
  endtask

  initial begin : g_watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, got hang, expected $finish");
    $fatal(1);
  end

  initial begin : g_main
    logic [DW-1:0] r;
    logic          b;
    int p0, q0, v0, h0, s0;
    int t;

    for (int g = 0; g < 2; g++) begin
      rst_n[g] = 1'b0; start[g] = 1'b0; leaf_valid[g] = 1'b0; leaf_data[g] = '0;
      force_full[g] = 1'b0; spur[g] = 1'b0; rdy_dly[g] = 0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check_eq("reset_ctl", {leaf_ready[g], hreq[g], push[g], pop[g], root_v[g], busy[g], err[g]}, 0);
      check_eq("reset_data", hleft[g] | hright[g] | sdin[g] | root_d[g], 0);
    end
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    // T1: HEIGHT=2, leaves 1..4 -> (1+2)+(3+4) = 10
    p0 = push_cnt[0]; q0 = pop_cnt[0]; v0 = rv_cnt[0];
    pulse_start(0);
    check_eq("t1_busy_after_start", busy[0], 1);
    run_four(0, 1, r, b);
    check_eq("t1_root", r, 10);
    check_eq("t1_busy_at_root", b, 0);
    repeat (3) @(negedge clk);
    check_eq("t1_pushes", push_cnt[0] - p0, 3);
    check_eq("t1_pops", pop_cnt[0] - q0, 3);
    check_eq("t1_root_pulses", rv_cnt[0] - v0, 1);
    check_eq("t1_stack_depth", depth[0], 0);
    check_eq("t1_root_held", root_d[0], 10);

    // T2: same tree, hash_ready held back for several cycles per request
    rdy_dly[0] = 5; h0 = hold_cnt[0]; s0 = hs_cnt[0];
    pulse_start(0);
    run_four(0, 1, r, b);
    check_eq("t2_root", r, 10);
    check_eq("t2_operand_hold_violations", hold_cnt[0] - h0, 0);
    check_eq("t2_hash_handshakes", hs_cnt[0] - s0, 3);
    rdy_dly[0] = 0;

    // T3: HEIGHT=1, leaves 7,9 -> 16
    p0 = push_cnt[1]; q0 = pop_cnt[1];
    pulse_start(1);
    feed_leaf(1, 7);
    feed_leaf(1, 9);
    wait_root(1, r, b);
    check_eq("t3_root", r, 16);
    check_eq("t3_busy_at_root", b, 0);
    check_eq("t3_pushes", push_cnt[1] - p0, 1);
    check_eq("t3_pops", pop_cnt[1] - q0, 1);
    check_eq("t3_stack_depth", depth[1], 0);

    // T4: stack reports full on the first push -> error, then restart
    force_full[0] = 1'b1; p0 = push_cnt[0];
    pulse_start(0);
    feed_leaf(0, 5);
    repeat (4) @(negedge clk);
    check_eq("t4_error", err[0], 1);
    check_eq("t4_busy", busy[0], 0);
    check_eq("t4_no_push", push_cnt[0] - p0, 0);
    check_eq("t4_leaf_ready_low", leaf_ready[0], 0);
    force_full[0] = 1'b0;
    start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    check_eq("t4_error_cleared", err[0], 0);
    check_eq("t4_leaf_ready", leaf_ready[0], 1);
    check_eq("t4_busy_again", busy[0], 1);
    run_four(0, 1, r, b);
    check_eq("t4_root_after_restart", r, 10);

    // T5: async reset while the hash core is working
    pulse_start(0);
    feed_leaf(0, 1);
    feed_leaf(0, 2);
    t = 0;
    while (!(hreq[0] && hash_ready[0]) && t < 100) begin @(negedge clk); t++; end
    check_eq("t5_handshake_seen", hreq[0] && hash_ready[0], 1);
    @(posedge clk); #1;
    check_eq("t5_busy_before_reset", busy[0], 1);
    #1 rst_n[0] = 1'b0;
    #1;
    check_eq("t5_reset_ctl", {leaf_ready[0], hreq[0], push[0], pop[0], root_v[0], busy[0], err[0]}, 0);
    check_eq("t5_reset_root", root_d[0], 0);
    check_eq("t5_reset_operands", hleft[0] | hright[0] | sdin[0], 0);
    @(negedge clk); rst_n[0] = 1'b1;
    p0 = push_cnt[0];
    pulse_start(0);
    run_four(0, 5, r, b);
    check_eq("t5_root_after_reset", r, 26);
    check_eq("t5_pushes", push_cnt[0] - p0, 3);

    // T6: start while busy and a stray hash response in WAIT_LEAF
    pulse_start(0);
    feed_leaf(0, 1);
    t = 0;
    while (!leaf_ready[0] && t < 100) begin @(negedge clk); t++; end
    start[0] = 1'b1; spur[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0; spur[0] = 1'b0;
    check_eq("t6_still_busy", busy[0], 1);
    feed_leaf(0, 2);
    feed_leaf(0, 3);
    feed_leaf(0, 4);
    wait_root(0, r, b);
    check_eq("t6_root", r, 10);
    check_eq("t6_stack_depth", depth[0], 0);

    check_eq("push_pop_overlap_0", excl_cnt[0], 0);
    check_eq("push_pop_overlap_1", excl_cnt[1], 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
